// File: rtl/wb_arbiter_if.sv
// Write-back request/response bundle between the ALU/memory paths,
// the arbiter, and the register bank write port.
interface wb_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_dest;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_dest;
    logic [15:0] mem_data;
    logic [15:0] wb_data;
    logic [15:0] reg_enable;
    logic        busy;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output mem_valid, mem_dest, mem_data,
        input  alu_ready, mem_ready,
        input  wb_data, reg_enable, busy
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  mem_valid, mem_dest, mem_data,
        output alu_ready, mem_ready,
        output wb_data, reg_enable, busy
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: one holding slot per source, memory-first
// priority with a starvation escape for the ALU.
module wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter bit R0_READONLY  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT) + 1;

    typedef enum logic {MEM_PRI, ALU_PRI} state_t;
    typedef enum logic [1:0] {G_NONE, G_ALU, G_MEM} grant_t;

    logic          r_alu_v;
    logic [3:0]    r_alu_dest;
    logic [15:0]   r_alu_data;
    logic          r_mem_v;
    logic [3:0]    r_mem_dest;
    logic [15:0]   r_mem_data;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_wb_data;
    logic [15:0]   r_reg_en;

    grant_t        w_grant;
    state_t        w_next_state;
    logic [CW-1:0] w_next_cnt;
    logic          w_alu_ready;
    logic          w_mem_ready;
    logic          w_alu_acc;
    logic          w_mem_acc;
    logic [3:0]    w_g_dest;
    logic [15:0]   w_g_data;
    logic [15:0]   w_g_en;

    // Grant looks only at the holds, so ready never depends on valid.
    always_comb begin
        w_grant = G_NONE;
        unique case (r_state)
            MEM_PRI: begin
                if (r_mem_v)      w_grant = G_MEM;
                else if (r_alu_v) w_grant = G_ALU;
            end
            ALU_PRI: begin
                if (r_alu_v)      w_grant = G_ALU;
                else if (r_mem_v) w_grant = G_MEM;
            end
            default: w_grant = G_NONE;
        endcase
    end

    assign w_alu_ready = !r_alu_v || (w_grant == G_ALU);
    assign w_mem_ready = !r_mem_v || (w_grant == G_MEM);
    assign w_alu_acc   = bus.alu_valid && w_alu_ready;
    assign w_mem_acc   = bus.mem_valid && w_mem_ready;

    always_comb begin
        w_g_dest = r_alu_dest;
        w_g_data = r_alu_data;
        if (w_grant == G_MEM) begin
            w_g_dest = r_mem_dest;
            w_g_data = r_mem_data;
        end
        w_g_en = 16'(1) << w_g_dest;
        if (R0_READONLY && (w_g_dest == 4'd0)) w_g_en = 16'h0000;
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        unique case (r_state)
            MEM_PRI: begin
                if (w_grant == G_ALU) begin
                    w_next_cnt = '0;
                end else if (r_alu_v && (w_grant == G_MEM)) begin
                    if (r_cnt >= CW'(STARVE_LIMIT - 1)) w_next_state = ALU_PRI;
                    if (r_cnt < CW'(STARVE_LIMIT)) w_next_cnt = r_cnt + CW'(1);
                end
            end
            ALU_PRI: begin
                if (w_grant == G_ALU) begin
                    w_next_state = MEM_PRI;
                    w_next_cnt   = '0;
                end
            end
            default: w_next_state = MEM_PRI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_v    <= 1'b0;
            r_alu_dest <= 4'd0;
            r_alu_data <= 16'h0000;
            r_mem_v    <= 1'b0;
            r_mem_dest <= 4'd0;
            r_mem_data <= 16'h0000;
            r_state    <= MEM_PRI;
            r_cnt      <= '0;
            r_wb_data  <= 16'h0000;
            r_reg_en   <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            // A hold retiring this edge may be refilled on the same edge.
            if (w_alu_acc) begin
                r_alu_v    <= 1'b1;
                r_alu_dest <= bus.alu_dest;
                r_alu_data <= bus.alu_data;
            end else if (w_grant == G_ALU) begin
                r_alu_v <= 1'b0;
            end
            if (w_mem_acc) begin
                r_mem_v    <= 1'b1;
                r_mem_dest <= bus.mem_dest;
                r_mem_data <= bus.mem_data;
            end else if (w_grant == G_MEM) begin
                r_mem_v <= 1'b0;
            end
            if (w_grant != G_NONE) begin
                r_wb_data <= w_g_data;
                r_reg_en  <= w_g_en;
            end else begin
                r_reg_en  <= 16'h0000;
            end
        end
    end

    assign bus.alu_ready  = w_alu_ready;
    assign bus.mem_ready  = w_mem_ready;
    assign bus.wb_data    = r_wb_data;
    assign bus.reg_enable = r_reg_en;
    assign bus.busy       = r_alu_v | r_mem_v;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus queues expected bank
// writes, a negedge monitor matches every reg_enable pulse.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int          cyc;
        logic [15:0] en;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];

    wb_arbiter_if a ();
    wb_arbiter_if r ();

    wb_arbiter #(.STARVE_LIMIT(4), .R0_READONLY(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (a.slave)
    );

    wb_arbiter #(.STARVE_LIMIT(4), .R0_READONLY(1'b1)) dut_r0 (
        .clk   (clk),
        .reset (reset),
        .bus   (r.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a.reg_enable != 16'h0000) begin
            if (q.size() == 0) begin
                chk("mon_unexpected", {16'h0, a.reg_enable}, 32'h0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("mon_en", {16'h0, a.reg_enable}, {16'h0, e.en});
                chk("mon_data", {16'h0, a.wb_data}, {16'h0, e.data});
                chk("mon_cyc", cyc, e.cyc);
            end
        end
    end

    task automatic idle_a();
        a.alu_valid = 1'b0;
        a.mem_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int k;
        a.alu_valid = 1'b1; a.alu_dest = 4'd1; a.alu_data = 16'h1234;
        a.mem_valid = 1'b1; a.mem_dest = 4'd2; a.mem_data = 16'h5678;
        r.alu_valid = 1'b1; r.alu_dest = 4'd1; r.alu_data = 16'h1234;
        r.mem_valid = 1'b0; r.mem_dest = 4'd0; r.mem_data = 16'h0000;

        // 1: reset held two edges with requests pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_a();
        r.alu_valid = 1'b0;
        chk("rst_en", {16'h0, a.reg_enable}, 32'h0);
        chk("rst_wb", {16'h0, a.wb_data}, 32'h0);
        chk("rst_busy", {31'h0, a.busy}, 32'h0);
        chk("rst_r0_busy", {31'h0, r.busy}, 32'h0);
        @(negedge clk);
        chk("rst_busy2", {31'h0, a.busy}, 32'h0);
        chk("rst_en2", {16'h0, a.reg_enable}, 32'h0);

        // 2: single ALU write
        k = cyc;
        a.alu_valid = 1'b1; a.alu_dest = 4'd5; a.alu_data = 16'hBEEF;
        chk("t2_ready", {31'h0, a.alu_ready}, 32'h1);
        q.push_back('{k + 2, 16'h0020, 16'hBEEF});
        @(negedge clk);
        idle_a();
        chk("t2_busy", {31'h0, a.busy}, 32'h1);
        repeat (4) @(negedge clk);
        chk("t2_wb_hold", {16'h0, a.wb_data}, 32'h0000BEEF);
        chk("t2_idle", {31'h0, a.busy}, 32'h0);
        drain(4);

        // 3: same dest from both sources on the same edge
        @(negedge clk);
        k = cyc;
        a.alu_valid = 1'b1; a.alu_dest = 4'd3; a.alu_data = 16'h1111;
        a.mem_valid = 1'b1; a.mem_dest = 4'd3; a.mem_data = 16'h2222;
        q.push_back('{k + 2, 16'h0008, 16'h2222});
        q.push_back('{k + 3, 16'h0008, 16'h1111});
        @(negedge clk);
        idle_a();
        chk("t3_alu_rdy", {31'h0, a.alu_ready}, 32'h0);
        chk("t3_mem_rdy", {31'h0, a.mem_ready}, 32'h1);
        drain(6);

        // 4: memory streams every cycle while ALU waits
        @(negedge clk);
        k = cyc;
        q.push_back('{k + 2, 16'h0200, 16'h5000});
        q.push_back('{k + 3, 16'h0200, 16'h5001});
        q.push_back('{k + 4, 16'h0200, 16'h5002});
        q.push_back('{k + 5, 16'h0200, 16'h5003});
        q.push_back('{k + 6, 16'h0080, 16'hAAAA});
        q.push_back('{k + 7, 16'h0200, 16'h5004});
        for (int j = 0; j < 6; j++) begin
            a.mem_valid = 1'b1;
            a.mem_dest  = 4'd9;
            a.mem_data  = 16'h5000 + 16'(j);
            a.alu_valid = (j == 0);
            a.alu_dest  = 4'd7;
            a.alu_data  = 16'hAAAA;
            if (j == 0) chk("t4_alu_rdy", {31'h0, a.alu_ready}, 32'h1);
            chk($sformatf("t4_mem_rdy%0d", j), {31'h0, a.mem_ready},
                (j < 5) ? 32'h1 : 32'h0);
            @(negedge clk);
        end
        idle_a();
        drain(8);

        // 5: dest 0 writes on both configurations
        @(negedge clk);
        k = cyc;
        a.alu_valid = 1'b1; a.alu_dest = 4'd0; a.alu_data = 16'h0F0F;
        q.push_back('{k + 2, 16'h0001, 16'h0F0F});
        r.alu_valid = 1'b1; r.alu_dest = 4'd0; r.alu_data = 16'h00FF;
        chk("t5_r0_rdy", {31'h0, r.alu_ready}, 32'h1);
        @(negedge clk);
        idle_a();
        r.alu_valid = 1'b0;
        chk("t5_r0_busy", {31'h0, r.busy}, 32'h1);
        chk("t5_r0_rdy2", {31'h0, r.alu_ready}, 32'h1);
        @(negedge clk);
        chk("t5_r0_en", {16'h0, r.reg_enable}, 32'h0);
        chk("t5_r0_wb", {16'h0, r.wb_data}, 32'h000000FF);
        chk("t5_r0_idle", {31'h0, r.busy}, 32'h0);
        r.alu_valid = 1'b1; r.alu_dest = 4'd2; r.alu_data = 16'h1234;
        @(negedge clk);
        r.alu_valid = 1'b0;
        @(negedge clk);
        chk("t5_r0_en2", {16'h0, r.reg_enable}, 32'h00000004);
        drain(4);

        // 6: reset lands between accept and retire
        @(negedge clk);
        a.alu_valid = 1'b1; a.alu_dest = 4'd4; a.alu_data = 16'hDEAD;
        @(negedge clk);
        idle_a();
        chk("t6_busy", {31'h0, a.busy}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_en", {16'h0, a.reg_enable}, 32'h0);
        chk("t6_busy2", {31'h0, a.busy}, 32'h0);
        repeat (3) @(negedge clk);
        chk("t6_en2", {16'h0, a.reg_enable}, 32'h0);
        chk("t6_q", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
